// File: rtl/seq_div32.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, C-style truncating results.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; otherwise operands are treated as unsigned.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, dvd, dvs;
    logic             dz;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] mag1, mag2, q_fix, r_fix, r_src;

    // On divide-by-zero the dividend magnitude is still sitting in dvd and becomes the remainder.
    assign r_src = dz ? dvd : rem;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q, neg_r;

    // Negating -2^(W-1) wraps to itself, which is the right unsigned magnitude.
    assign mag1  = op1[WIDTH-1] ? -op1 : op1;
    assign mag2  = op2[WIDTH-1] ? -op2 : op2;
    assign q_fix = dz ? '1 : (neg_q ? -dvd : dvd);
    assign r_fix = neg_r ? -r_src : r_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= op1[WIDTH-1] ^ op2[WIDTH-1];
            neg_r <= op1[WIDTH-1];
        end
    end
`else
    assign mag1  = op1;
    assign mag2  = op2;
    assign q_fix = dz ? '1 : dvd;
    assign r_fix = r_src;
`endif

    assign shifted = {rem, dvd[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = (op2 == '0) ? FIX : CALC;
            CALC: begin
                busy = 1'b1;
                if (count == LAST) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            rem       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvd      <= mag1;
                    dvs      <= mag2;
                    rem      <= '0;
                    count    <= '0;
                    dz       <= (op2 == '0);
                    div_zero <= 1'b0;
                end
                CALC: begin
                    // Quotient bits shift into dvd from the bottom as dividend bits leave the top.
                    count <= count + 1'b1;
                    dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule
